// File: rtl/cmult_pkg.sv
// Shared types and constants for the complex-multiplier arbiter: FSM encoding,
// default operand width and the grant-index width helper.
package cmult_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_t;

    localparam int CMULT_DATA_WIDTH = 8;

    // Never returns less than 1 so a grant index always has at least one bit.
    function automatic int cmult_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: zero latency, no state; searches upward from
// last_grant+1 with wrap and returns a one-hot grant plus its index.
module rr_arbiter
    import cmult_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = cmult_clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_val,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    int   w_idx;
    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(last_grant) + k) % N_REQ;
            if (!w_found && req_val[w_idx]) begin
                w_found        = 1'b1;
                grant[w_idx]   = 1'b1;
                grant_idx      = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/complex_mult_arbiter.sv
// Shares one complex multiplier among N_REQ requesters, one transaction in flight; min 4 cycles
// plus compute, stalls on mult_op_ready/rsp_ready. CMA_STATS_EN adds saturating grant counters.
module complex_mult_arbiter
    import cmult_pkg::*;
#(
    parameter int DATA_WIDTH = CMULT_DATA_WIDTH,
    parameter int N_REQ      = 4
`ifdef CMA_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sw_rst,
    input  logic [N_REQ-1:0]              req_val,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_op_1_re,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_op_1_im,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_op_2_re,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_op_2_im,
    output logic [N_REQ-1:0]              rsp_val,
    input  logic [N_REQ-1:0]              rsp_ready,
    output logic [2*DATA_WIDTH-1:0]       rsp_result_re,
    output logic [2*DATA_WIDTH-1:0]       rsp_result_im,
    output logic                          mult_op_val,
    input  logic                          mult_op_ready,
    output logic [DATA_WIDTH-1:0]         mult_op_1_re,
    output logic [DATA_WIDTH-1:0]         mult_op_1_im,
    output logic [DATA_WIDTH-1:0]         mult_op_2_re,
    output logic [DATA_WIDTH-1:0]         mult_op_2_im,
    input  logic                          mult_res_val,
    output logic                          mult_res_ready,
    input  logic [2*DATA_WIDTH-1:0]       mult_result_re,
    input  logic [2*DATA_WIDTH-1:0]       mult_result_im,
    output logic                          busy,
    output logic [cmult_clog2(N_REQ)-1:0] grant_id
`ifdef CMA_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]        grant_cnt
`endif
);

    localparam int IDX_W = cmult_clog2(N_REQ);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [N_REQ-1:0]        w_grant;
    logic [IDX_W-1:0]        w_grant_idx;
    logic [IDX_W-1:0]        r_last_grant;
    logic [IDX_W-1:0]        r_grant_id;
    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   r_op_1_re;
    logic [DATA_WIDTH-1:0]   r_op_1_im;
    logic [DATA_WIDTH-1:0]   r_op_2_re;
    logic [DATA_WIDTH-1:0]   r_op_2_im;
    logic [2*DATA_WIDTH-1:0] r_res_re;
    logic [2*DATA_WIDTH-1:0] r_res_im;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_val    (req_val),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    // sw_rst wins over an acceptance in the same cycle, so no ready pulse may escape.
    assign w_accept  = (r_state == IDLE) && (|req_val) && !sw_rst;
    assign req_ready = w_accept ? w_grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else if (sw_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        mult_op_val    = 1'b0;
        mult_res_ready = 1'b0;
        rsp_val        = '0;
        case (r_state)
            IDLE: begin
                if (|req_val) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                mult_op_val = 1'b1;
                if (mult_op_ready) begin
                    w_next_state = WAIT_RES;
                end
            end
            WAIT_RES: begin
                mult_res_ready = 1'b1;
                if (mult_res_val) begin
                    w_next_state = DELIVER;
                end
            end
            DELIVER: begin
                rsp_val[r_grant_id] = 1'b1;
                if (rsp_ready[r_grant_id]) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_grant_id   <= '0;
            r_op_1_re    <= '0;
            r_op_1_im    <= '0;
            r_op_2_re    <= '0;
            r_op_2_im    <= '0;
            r_res_re     <= '0;
            r_res_im     <= '0;
        end else if (sw_rst) begin
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_grant_id   <= '0;
            r_op_1_re    <= '0;
            r_op_1_im    <= '0;
            r_op_2_re    <= '0;
            r_op_2_im    <= '0;
            r_res_re     <= '0;
            r_res_im     <= '0;
        end else begin
            if (w_accept) begin
                r_grant_id <= w_grant_idx;
                r_op_1_re  <= req_op_1_re[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_op_1_im  <= req_op_1_im[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_op_2_re  <= req_op_2_re[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_op_2_im  <= req_op_2_im[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            if ((r_state == WAIT_RES) && mult_res_val) begin
                r_res_re <= mult_result_re;
                r_res_im <= mult_result_im;
            end
            // Priority only rotates once the owner has actually taken its result.
            if ((r_state == DELIVER) && rsp_ready[r_grant_id]) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    assign mult_op_1_re  = r_op_1_re;
    assign mult_op_1_im  = r_op_1_im;
    assign mult_op_2_re  = r_op_2_re;
    assign mult_op_2_im  = r_op_2_im;
    assign rsp_result_re = r_res_re;
    assign rsp_result_im = r_res_im;
    assign busy          = (r_state != IDLE);
    assign grant_id      = r_grant_id;

`ifdef CMA_STATS_EN
    logic [CNT_W-1:0] r_cnt [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
        end else if (sw_rst) begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Scoreboard bench for complex_mult_arbiter with a behavioural multiplier on the far side.
module tb_complex_mult_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;

    logic           clk;
    logic           rst;
    logic           sw_rst;
    logic [NR-1:0]  req_val;
    logic [NR-1:0]  req_ready;
    logic [NR*DW-1:0] req_op_1_re, req_op_1_im, req_op_2_re, req_op_2_im;
    logic [NR-1:0]  rsp_val;
    logic [NR-1:0]  rsp_ready;
    logic [2*DW-1:0] rsp_result_re, rsp_result_im;
    logic           mult_op_val;
    logic           mult_op_ready;
    logic [DW-1:0]  mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im;
    logic           mult_res_val;
    logic           mult_res_ready;
    logic [2*DW-1:0] mult_result_re, mult_result_im;
    logic           busy;
    logic [1:0]     grant_id;
`ifdef CMA_STATS_EN
    logic [NR*2-1:0] grant_cnt;
`endif

    complex_mult_arbiter #(
        .DATA_WIDTH (DW),
        .N_REQ      (NR)
`ifdef CMA_STATS_EN
        ,
        .CNT_W      (2)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_rst         (sw_rst),
        .req_val        (req_val),
        .req_ready      (req_ready),
        .req_op_1_re    (req_op_1_re),
        .req_op_1_im    (req_op_1_im),
        .req_op_2_re    (req_op_2_re),
        .req_op_2_im    (req_op_2_im),
        .rsp_val        (rsp_val),
        .rsp_ready      (rsp_ready),
        .rsp_result_re  (rsp_result_re),
        .rsp_result_im  (rsp_result_im),
        .mult_op_val    (mult_op_val),
        .mult_op_ready  (mult_op_ready),
        .mult_op_1_re   (mult_op_1_re),
        .mult_op_1_im   (mult_op_1_im),
        .mult_op_2_re   (mult_op_2_re),
        .mult_op_2_im   (mult_op_2_im),
        .mult_res_val   (mult_res_val),
        .mult_res_ready (mult_res_ready),
        .mult_result_re (mult_result_re),
        .mult_result_im (mult_result_im),
        .busy           (busy),
        .grant_id       (grant_id)
`ifdef CMA_STATS_EN
        ,
        .grant_cnt      (grant_cnt)
`endif
    );

    typedef struct {
        int          id;
        logic [15:0] re;
        logic [15:0] im;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   posted [NR];
    int   pulses [NR];
    int   pulses_tot = 0;
    int   cyc = 0;
    int   req_cyc = 0;
    int   rsp_seen = 0;
    int   mult_lat = 2;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NR; i++) req_val[i] = (posted[i] > pulses[i]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cmul(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
        int sa, sb_, sc, sd, re, im;
        sa = $signed(a); sb_ = $signed(b); sc = $signed(c); sd = $signed(d);
        re = sa * sc - sb_ * sd;
        im = sa * sd + sb_ * sc;
        return {im[15:0], re[15:0]};
    endfunction

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        req_op_1_re[i*DW +: DW] = a;
        req_op_1_im[i*DW +: DW] = b;
        req_op_2_re[i*DW +: DW] = c;
        req_op_2_im[i*DW +: DW] = d;
    endtask

    task automatic push(input int i);
        exp_t e;
        logic [31:0] r;
        r = cmul(req_op_1_re[i*DW +: DW], req_op_1_im[i*DW +: DW],
                 req_op_2_re[i*DW +: DW], req_op_2_im[i*DW +: DW]);
        e.id = i; e.re = r[15:0]; e.im = r[31:16];
        sb.push_back(e);
    endtask

    task automatic pulse_sw_rst();
        @(posedge clk); #1 sw_rst = 1'b1;
        @(posedge clk); #1 sw_rst = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy || (|req_val)) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({"done_", tag}, 32'(k < budget), 1);
    endtask

    // Request handshake monitor: counts ready pulses, retires them after the edge.
    initial begin : req_mon
        logic [NR-1:0] seen;
        for (int i = 0; i < NR; i++) pulses[i] = 0;
        forever begin
            @(negedge clk);
            seen = rst ? '0 : req_ready;
            if (|seen) req_cyc = cyc;
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (seen[i]) begin
                    pulses[i]++;
                    pulses_tot++;
                end
            end
        end
    end

    initial begin : mult_model
        logic [31:0] r;
        int k;
        mult_res_val = 1'b0; mult_result_re = '0; mult_result_im = '0;
        forever begin
            @(negedge clk);
            if (!rst && !sw_rst && mult_op_val && mult_op_ready) begin
                r = cmul(mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im);
                @(posedge clk);
                repeat (mult_lat - 1) @(posedge clk);
                #1;
                mult_res_val = 1'b1; mult_result_re = r[15:0]; mult_result_im = r[31:16];
                k = 0;
                do begin @(negedge clk); k++; end while (!(mult_res_ready && !sw_rst) && k < 30);
                @(posedge clk); #1 mult_res_val = 1'b0;
            end
        end
    end

    initial begin : rsp_check
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !sw_rst) begin
                if (|rsp_val) rsp_seen++;
                if (|(rsp_val & rsp_ready)) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'(rsp_val), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_onehot", 32'(rsp_val), 32'(1 << e.id));
                        chk("rsp_grant_id", 32'(grant_id), 32'(e.id));
                        chk("rsp_re", 32'(rsp_result_re), 32'(e.re));
                        chk("rsp_im", 32'(rsp_result_im), 32'(e.im));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k, p0, s0;
        exp_t e;
        rst = 1'b1; sw_rst = 1'b0; mult_op_ready = 1'b1; rsp_ready = '1;
        req_op_1_re = '0; req_op_1_im = '0; req_op_2_re = '0; req_op_2_im = '0;
        for (int i = 0; i < NR; i++) posted[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_rsp_val", 32'(rsp_val), 0);
        chk("rst_op_val", 32'(mult_op_val), 0);
        chk("rst_res_rdy", 32'(mult_res_ready), 0);
        chk("rst_op1re", 32'(mult_op_1_re), 0);
        chk("rst_res_re", 32'(rsp_result_re), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Single requester 1: (3+4j)*(2+5j) = -14 + 23j
        @(posedge clk); #1;
        set_ops(1, 8'd3, 8'd4, 8'd2, 8'd5);
        e.id = 1; e.re = 16'hFFF2; e.im = 16'd23;
        sb.push_back(e);
        p0 = pulses[1];
        posted[1]++;
        k = 0;
        do begin @(negedge clk); k++; end while (!mult_op_val && k < 20);
        chk("lat_op_val", 32'(cyc - req_cyc), 1);
        wait_done("single", 100);
        chk("single_pulses", 32'(pulses[1] - p0), 1);

        // All four held: strict order 0,1,2,3,0 from a fresh priority pointer
        pulse_sw_rst();
        for (int i = 0; i < NR; i++)
            set_ops(i, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        push(0); push(1); push(2); push(3); push(0);
        posted[0] += 2; posted[1]++; posted[2]++; posted[3]++;
        wait_done("rr", 400);

        // Multiplier refuses operands for 5 cycles
        mult_op_ready = 1'b0;
        set_ops(2, 8'h81, 8'h7f, 8'hc3, 8'h10);
        push(2);
        posted[2]++;
        k = 0;
        do begin @(negedge clk); k++; end while (!mult_op_val && k < 20);
        repeat (5) begin
            chk("stall_op_val", 32'(mult_op_val), 1);
            chk("stall_op1re", 32'(mult_op_1_re), 32'h81);
            chk("stall_op2im", 32'(mult_op_2_im), 32'h10);
            chk("stall_res_rdy", 32'(mult_res_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 mult_op_ready = 1'b1;
        wait_done("op_stall", 100);

        // Owner 3 stalls delivery while 0 waits and non-owners offer rsp_ready
        rsp_ready = 4'b0111;
        set_ops(3, 8'd100, 8'hf6, 8'd7, 8'd9);
        set_ops(0, 8'd1, 8'd2, 8'd3, 8'd4);
        push(3); push(0);
        posted[3]++; posted[0]++;
        k = 0;
        do begin @(negedge clk); k++; end while (!rsp_val[3] && k < 30);
        p0 = pulses_tot;
        e = sb[0];
        repeat (10) begin
            chk("dstall_val", 32'(rsp_val), 32'h8);
            chk("dstall_re", 32'(rsp_result_re), 32'(e.re));
            chk("dstall_im", 32'(rsp_result_im), 32'(e.im));
            @(negedge clk);
        end
        chk("dstall_no_req", 32'(pulses_tot - p0), 0);
        @(posedge clk); #1 rsp_ready = '1;
        wait_done("rsp_stall", 100);

        // sw_rst in WAIT_RES abandons the transaction; late result is ignored
        mult_lat = 4;
        set_ops(1, 8'd9, 8'd9, 8'd9, 8'd9);
        posted[1]++;
        k = 0;
        do begin @(negedge clk); k++; end while (!mult_res_ready && k < 30);
        s0 = rsp_seen;
        pulse_sw_rst();
        @(negedge clk);
        chk("swr_busy", 32'(busy), 0);
        chk("swr_res_rdy", 32'(mult_res_ready), 0);
        repeat (40) @(posedge clk);
        chk("swr_no_rsp", 32'(rsp_seen - s0), 0);
        mult_lat = 2;
        @(posedge clk); #1;
        set_ops(0, 8'd5, 8'hfb, 8'd2, 8'd1);
        set_ops(1, 8'd6, 8'd7, 8'd8, 8'hff);
        push(0); push(1);
        posted[0]++; posted[1]++;
        wait_done("after_swr", 200);

`ifdef CMA_STATS_EN
        pulse_sw_rst();
        set_ops(2, 8'd1, 8'd1, 8'd1, 8'd1);
        for (int i = 0; i < 5; i++) push(2);
        posted[2] += 5;
        wait_done("stats", 400);
        chk("cnt2_sat", 32'(grant_cnt[4 +: 2]), 3);
        chk("cnt0_zero", 32'(grant_cnt[0 +: 2]), 0);
`endif

        repeat (5) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
